mem_bus_slave: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/mem_bus_ram.sv | 32 +++
 rtl/mem_bus_slave.sv | 145 ++++++++++++++
 tb/tb_mem_bus_slave.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the main-memory bus endpoint: FSM encoding and sizing constants.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_HOLD   = 2'b10
  } state_t;

  // Default RAM depth in words; the top-level MEM_DEPTH parameter defaults to this.
  localparam int MEM_DEPTH_DEF = 1024;

  // Word-index width for the default depth.
  localparam int IDX_W = $clog2(MEM_DEPTH_DEF);

  // Access-latency down-counter width; holds LATENCY-1 for LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port synchronous word RAM backing the memory bus endpoint.
// The read register only updates on an enabled read, so a response stays
// visible after the access until the next read.
module mem_bus_ram
  import mem_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter     INIT_FILE  = ""
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] idx,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // One access per enabled cycle: write, or registered read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/mem_bus_slave.sv
// Main-memory bus endpoint: accepts one outstanding request from the arbiter,
// waits LATENCY cycles in ACCESS, then performs the RAM access and pulses
// data_valid (and bus_err for out-of-range addresses) for one cycle.
module mem_bus_slave
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int LATENCY    = 2,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wrt_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  data_valid,
  output logic                  bus_err,
  output logic                  busy
);

  localparam int IW = $clog2(MEM_DEPTH);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_bus_slave: LATENCY must be in 1..15");
  end
  if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_bus_slave: MEM_DEPTH must be a power of two");
  end

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  dv_n, err_n;
  logic                  rd_sel, rd_sel_n;
  logic                  accept;
  logic                  ram_en, ram_we;
  logic                  oor;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_lsb;

  // Byte-lane bits are not used for word addressing.
  assign unused_lsb = ^addr[1:0];

  // Any latched address bit above the word index marks the access out of range.
  assign oor = (addr_q >> (IW + 2)) != '0;

  // rd_sel clear means the last read was out of range (or none since reset): return zero.
  assign rd_data = rd_sel ? ram_rdata : '0;

  assign busy = (state == S_ACCESS) || (state == S_HOLD);

  // Control state, latency counter and response flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      data_valid <= 1'b0;
      bus_err    <= 1'b0;
      rd_sel     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      data_valid <= dv_n;
      bus_err    <= err_n;
      rd_sel     <= rd_sel_n;
    end
  end

  // Request fields are captured on acceptance and held for the whole transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr;
      we_q    <= we;
      wdata_q <= wrt_data;
    end
  end

  // Next-state, counter and RAM-access decode.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dv_n     = 1'b0;
    err_n    = 1'b0;
    rd_sel_n = rd_sel;
    accept   = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_n   = CNT_W'(LATENCY - 1);
          state_n = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!req_valid) begin
          state_n = S_IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = S_HOLD;
          dv_n    = 1'b1;
          err_n   = oor;
          ram_en  = !oor;
          ram_we  = we_q;
          if (!we_q) begin
            rd_sel_n = !oor;
          end
        end
      end
      S_HOLD: begin
        if (!req_valid) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // A reset arriving on the access edge must not commit a write.
    if (reset) begin
      ram_en = 1'b0;
      accept = 1'b0;
    end
  end

  mem_bus_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .idx   (addr_q[2 +: IW]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_bus_slave.sv
// Self-checking bench for mem_bus_slave: directed scenarios followed by random
// transactions, compared every cycle against a timeline/memory model.
module tb_mem_bus_slave;

  localparam int LAT  = 2;
  localparam int MAXC = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wrt_data;
  logic [31:0] rd_data;
  logic        data_valid;
  logic        bus_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Expected-output timeline, indexed by cycle number.
  bit          e_busy   [MAXC];
  bit          e_dv     [MAXC];
  bit          e_err    [MAXC];
  bit          e_rdset  [MAXC];
  bit          e_rdknown[MAXC];
  logic [31:0] e_rdval  [MAXC];

  // Memory contents model; mk marks words whose value the bench knows.
  logic [31:0] mm [1024];
  bit          mk [1024];

  logic [31:0] m_rd    = 32'h0;
  bit          m_known = 1'b1;

  mem_bus_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (1024),
    .LATENCY    (LAT),
    .INIT_FILE  ("")
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .addr       (addr),
    .we         (we),
    .wrt_data   (wrt_data),
    .rd_data    (rd_data),
    .data_valid (data_valid),
    .bus_err    (bus_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model timeline.
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      if (e_rdset[cyc]) begin
        m_rd    = e_rdval[cyc];
        m_known = e_rdknown[cyc];
      end
      chk("data_valid", {31'b0, data_valid}, {31'b0, e_dv[cyc]});
      chk("bus_err",    {31'b0, bus_err},    {31'b0, e_err[cyc]});
      chk("busy",       {31'b0, busy},       {31'b0, e_busy[cyc]});
      if (m_known) chk("rd_data", rd_data, m_rd);
    end
  end

  // One bus transaction as the arbiter would issue it.
  // mode 0: complete; 1: drop req_valid in the first ACCESS cycle; 2: reset in the first ACCESS cycle.
  task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d, input int h,
                     input int mode, input bit lit, input logic [31:0] lit_rd, input logic lit_err);
    int n;
    int idx;
    int r;
    bit oor;
    @(posedge clk); #1;
    n = cyc;
    req_valid = 1'b1;
    addr      = a;
    we        = w;
    wrt_data  = d;
    oor = (a >> 12) != 0;
    idx = int'(a[11:2]);
    if (mode != 0) begin
      e_busy[n+1] = 1'b1;
      if (mode == 2) begin
        e_rdset[n+2]   = 1'b1;
        e_rdval[n+2]   = 32'h0;
        e_rdknown[n+2] = 1'b1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      addr      = $urandom;
      wrt_data  = $urandom;
      we        = ~w;
      if (mode == 2) reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end else begin
      r = n + LAT + 1;
      for (int k = n + 1; k <= r + h; k++) e_busy[k] = 1'b1;
      e_dv[r]  = 1'b1;
      e_err[r] = oor;
      if (!w) begin
        e_rdset[r]   = 1'b1;
        e_rdval[r]   = oor ? 32'h0 : mm[idx];
        e_rdknown[r] = oor || mk[idx];
      end else if (!oor) begin
        mm[idx] = d;
        mk[idx] = 1'b1;
      end
      for (int k = 1; k <= LAT + 1 + h; k++) begin
        @(posedge clk); #1;
        if (k == 1) begin
          addr     = $urandom;
          wrt_data = $urandom;
          we       = ~w;
        end
        if (k == LAT + 1 && lit) begin
          chk("lit_data_valid", {31'b0, data_valid}, 32'h1);
          chk("lit_bus_err",    {31'b0, bus_err},    {31'b0, lit_err});
          chk("lit_rd_data",    rd_data,             lit_rd);
        end
      end
      req_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a;
    int          mode;
    for (int i = 0; i < 1024; i++) begin
      mm[i] = 32'h0;
      mk[i] = 1'b0;
    end
    reset     = 1'b1;
    req_valid = 1'b0;
    addr      = 32'h0;
    we        = 1'b0;
    wrt_data  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy",       {31'b0, busy},       32'h0);
    chk("rst_data_valid", {31'b0, data_valid}, 32'h0);
    chk("rst_bus_err",    {31'b0, bus_err},    32'h0);
    chk("rst_rd_data",    rd_data,             32'h0);

    // Basic write/read, write leaves rd_data unchanged.
    txn(32'h0000_000C, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0, 1'b0);
    txn(32'h0000_000C, 1'b0, 32'h0,         0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    txn(32'h0000_0000, 1'b1, 32'h0BAD_F00D, 0, 0, 1'b0, 32'h0, 1'b0);
    txn(32'h0000_0040, 1'b1, 32'h1234_5678, 0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    txn(32'h0000_0040, 1'b0, 32'h0,         0, 0, 1'b1, 32'h1234_5678, 1'b0);
    // Out of range: aliases word 0 in the low bits but must not touch it.
    txn(32'h0000_1000, 1'b1, 32'hAAAA_5555, 0, 0, 1'b1, 32'h1234_5678, 1'b1);
    txn(32'h0000_1000, 1'b0, 32'h0,         0, 0, 1'b1, 32'h0, 1'b1);
    txn(32'h0000_0000, 1'b0, 32'h0,         0, 0, 1'b1, 32'h0BAD_F00D, 1'b0);
    // Abort leaves memory untouched.
    txn(32'h0000_0080, 1'b1, 32'h5A5A_0001, 0, 0, 1'b0, 32'h0, 1'b0);
    txn(32'h0000_0080, 1'b1, 32'hFFFF_FFFF, 0, 1, 1'b0, 32'h0, 1'b0);
    txn(32'h0000_0080, 1'b0, 32'h0,         0, 0, 1'b1, 32'h5A5A_0001, 1'b0);
    // Hold request high after the response, then re-arm.
    txn(32'h0000_0040, 1'b0, 32'h0,         3, 0, 1'b1, 32'h1234_5678, 1'b0);
    txn(32'h0000_000C, 1'b0, 32'h0,         0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    // Reset during ACCESS of a write.
    txn(32'h0000_0020, 1'b1, 32'h0000_2020, 0, 0, 1'b0, 32'h0, 1'b0);
    txn(32'h0000_0020, 1'b1, 32'hFFFF_0000, 0, 2, 1'b0, 32'h0, 1'b0);
    txn(32'h0000_0020, 0,    32'h0,         0, 0, 1'b1, 32'h0000_2020, 1'b0);

    // Random traffic over a small window so reads hit earlier writes.
    for (int t = 0; t < 80 && cyc < MAXC - 60; t++) begin
      a = {22'h0, 4'($urandom_range(0, 15)), 4'h0, 2'($urandom_range(0, 3))};
      a[5:2] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) a = a | (32'($urandom_range(1, 1048575)) << 12);
      mode = ($urandom_range(0, 7) == 0) ? 1 : (($urandom_range(0, 14) == 0) ? 2 : 0);
      txn(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), mode, 1'b0, 32'h0, 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
